spi_slave_frame: RTL and testbench
==================================

// Module: spi_slave_frame
// PURPOSE
//  Parametrised SPI slave. It synchronises an external SPI master (Pico) into the 25 MHz fabric clock.
//  Supports all four CPOL/CPHA modes and full-duplex frames of DATA_BYTES bytes.
//  Frames are back-to-back while CS stays low; truncated frames are detected.
//  Per-byte and per-word strobes feed the debug/7-seg logic, and a holding register supplies the reply word.
// PARAMETERS
//  DATA_BYTES   4   bytes per word (1..8); word width W = 8*DATA_BYTES
//  CPOL         0   idle level of spi_clk
//  CPHA         0   0: sample on leading edge; 1: sample on trailing edge
//  SYNC_STAGES  2   synchroniser flops on spi_clk/spi_mosi/spi_cs_n (>=2)
//  MSB_FIRST    1   1: bit 7 of each byte first, byte W-1:W-8 first; 0: LSB/byte0 first
// PORTS
//  clk            in   1   fabric clock (25 MHz)
//  reset          in   1   asynchronous, active-high reset
//  spi_clk        in   1   SPI clock from master (async)
//  spi_mosi       in   1   master-out data (async)
//  spi_cs_n       in   1   chip select, active low (async)
//  spi_miso       out  1   slave-out data
//  spi_miso_oe    out  1   1 while frame active (tristate enable for pad)
//  tx_data        in   W   reply word
//  tx_load        in   1   1-cycle: latch tx_data into holding reg
//  tx_ready       out  1   1 = holding reg consumed, may load next
//  rx_data        out  W   last complete received word
//  rx_valid       out  1   1-cycle pulse: rx_data updated
//  rx_byte        out  8   last complete received byte
//  rx_byte_valid  out  1   1-cycle pulse: rx_byte updated
//  frame_active   out  1   FSM in ACTIVE
//  frame_error    out  1   1-cycle pulse: CS released mid-word
// BEHAVIOUR
//  Reset:
//  - All outputs 0 except tx_ready=1; FSM=IDLE.
//  - Sync regs reset to idle levels (cs_n=1, sclk=CPOL).
//  Sync/edges:
//  - Each input passes SYNC_STAGES flops; edges come from last stage vs one extra flop.
//  - Sample edge = rising if CPOL==CPHA, else falling; shift edge = the other edge.
//  - Constraint: each spi_clk phase >= SYNC_STAGES+2 clk cycles.
//  FSM IDLE:
//  - Detected cs_n fall -> ACTIVE; bit_cnt=0; shift_tx<=holding; tx_ready<=1.
//  - cs_n already low out of reset is NOT a fall; stays IDLE until cs_n seen high then low.
//  FSM ACTIVE:
//  - Sample edge: shift_rx takes mosi; bit_cnt++.
//  - Shift edge: shift_tx advances one bit, except when CPHA=1 and bit_cnt==0 (first leading edge only presents bit 0).
//  - spi_miso = current tx bit (MSB or LSB per MSB_FIRST); CPHA=0 bit 0 valid from ACTIVE entry.
//  - bit_cnt[2:0]==0 after increment: rx_byte<=assembled byte, rx_byte_valid pulse next cycle.
//  - bit_cnt==W: rx_data<=shift_rx, rx_valid pulse, bit_cnt wraps to 0, shift_tx<=holding, tx_ready<=1; frame continues.
//  - Detected cs_n rise -> IDLE. If bit_cnt!=0: frame_error pulse; partial word/byte discarded (no valid pulses).
//  Holding reg:
//  - tx_load: holding<=tx_data, tx_ready<=0.
//  - tx_load in the same cycle as a word reload: the new tx_data goes straight to shift_tx; tx_ready stays 1.
//  - If not reloaded, holding contents are resent.
//  - spi_miso_oe = frame_active; spi_miso=0 when IDLE.
//  Latency: rx_byte_valid/rx_valid assert SYNC_STAGES+2 clk after the physical sample edge.
//  Reset mid-frame: returns to IDLE immediately; the remaining bits of that frame are ignored.
// TESTING
//  1 Mode0, N=4, tx_load 0xCAFEBABE, master sends 0x12345678 -> miso 0xCAFEBABE; rx_byte 12,34,56,78 pulses; rx_valid with 0x12345678.
//  2 Modes 1,2,3 each: same word exchange -> identical rx_data/miso data as mode 0.
//  3 CS held low for 2 words, tx_load 0xA5A5A5A5 mid-word1 -> word2 miso=0xA5A5A5A5; 2 rx_valid pulses.
//  4 CS rises after 12 bits -> one rx_byte_valid, frame_error pulse, no rx_valid; next frame correct.
//  5 reset during bit 20, cs_n still low -> IDLE, all outputs 0; no activity until cs_n high->low.
//  6 MSB_FIRST=0, N=1, master sends 0x01 LSB-first -> rx_byte=0x01; miso 0x80 sent LSB first.

Source files
------------

// File: rtl/spi_slave_frame.sv
// SPI slave, all four CPOL/CPHA modes, full-duplex DATA_BYTES-wide words in the fabric clock domain.
// Inputs are synchronised and edge-detected. Frames run back-to-back while CS stays low.
module spi_slave_frame #(
    parameter int DATA_BYTES  = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      spi_clk,
    input  logic                      spi_mosi,
    input  logic                      spi_cs_n,
    output logic                      spi_miso,
    output logic                      spi_miso_oe,
    input  logic [8*DATA_BYTES-1:0]   tx_data,
    input  logic                      tx_load,
    output logic                      tx_ready,
    output logic [8*DATA_BYTES-1:0]   rx_data,
    output logic                      rx_valid,
    output logic [7:0]                rx_byte,
    output logic                      rx_byte_valid,
    output logic                      frame_active,
    output logic                      frame_error
);
    localparam int   W           = 8 * DATA_BYTES;
    localparam int   CW          = $clog2(W + 1);
    localparam logic SCLK_IDLE   = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam bit   SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, flush_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q, armed_d;
    logic                   sclk_last, cs_last, mosi_last;
    logic                   sclk_rise, sclk_fall, sample_edge, shift_edge, cs_fall, cs_rise;

    state_e                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d, cnt_next;
    logic [W-1:0]           shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d, holding_q, holding_d;
    logic [W-1:0]           rx_data_q, rx_data_d;
    logic [7:0]             rx_byte_q, rx_byte_d, byte_now;
    logic                   tx_ready_q, tx_ready_d, byte_pend_q, byte_pend_d, word_pend_q, word_pend_d;
    logic                   rx_valid_q, rx_valid_d, rx_byte_valid_q, rx_byte_valid_d;
    logic                   frame_error_q, frame_error_d, tx_bit, reload;

    // Synchronisers come out of reset at the bus idle levels, so no edge is seen on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sclk_prev_q <= SCLK_IDLE;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_last   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_last     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_last   = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_last & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_last & sclk_prev_q;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    // A fall only counts once CS has really been seen high after the synchroniser flushed.
    assign cs_fall     = armed_q & cs_prev_q & ~cs_last;
    assign cs_rise     = cs_last & ~cs_prev_q;
    assign cnt_next    = bit_cnt_q + CW'(1);
    assign tx_bit      = (MSB_FIRST != 0) ? shift_tx_q[W-1] : shift_tx_q[0];
    assign byte_now    = (MSB_FIRST != 0) ? shift_rx_q[7:0] : shift_rx_q[W-1 -: 8];

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d         = state_q;
        armed_d         = armed_q | (flush_q[SYNC_STAGES-1] & cs_last);
        bit_cnt_d       = bit_cnt_q;
        shift_rx_d      = shift_rx_q;
        shift_tx_d      = shift_tx_q;
        holding_d       = holding_q;
        tx_ready_d      = tx_ready_q;
        byte_pend_d     = 1'b0;
        word_pend_d     = 1'b0;
        frame_error_d   = 1'b0;
        rx_byte_d       = byte_pend_q ? byte_now : rx_byte_q;
        rx_byte_valid_d = byte_pend_q;
        rx_data_d       = word_pend_q ? shift_rx_q : rx_data_q;
        rx_valid_d      = word_pend_q;
        reload          = 1'b0;

        if (tx_load) begin
            holding_d  = tx_data;
            tx_ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    frame_error_d = (bit_cnt_q != '0);
                    bit_cnt_d     = '0;
                end else if (sample_edge) begin
                    shift_rx_d  = (MSB_FIRST != 0) ? {shift_rx_q[W-2:0], mosi_last}
                                                   : {mosi_last, shift_rx_q[W-1:1]};
                    byte_pend_d = (cnt_next[2:0] == 3'd0);
                    if (cnt_next == CW'(W)) begin
                        bit_cnt_d   = '0;
                        word_pend_d = 1'b1;
                        reload      = 1'b1;
                    end else begin
                        bit_cnt_d = cnt_next;
                    end
                end else if (shift_edge && bit_cnt_q != '0) begin
                    // At bit_cnt 0 the freshly loaded bit 0 must stay on the line.
                    shift_tx_d = (MSB_FIRST != 0) ? {shift_tx_q[W-2:0], 1'b0}
                                                  : {1'b0, shift_tx_q[W-1:1]};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            shift_tx_d = tx_load ? tx_data : holding_q;
            tx_ready_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the holding register is reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            armed_q         <= 1'b0;
            bit_cnt_q       <= '0;
            shift_rx_q      <= '0;
            shift_tx_q      <= '0;
            holding_q       <= '0;
            tx_ready_q      <= 1'b1;
            byte_pend_q     <= 1'b0;
            word_pend_q     <= 1'b0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            armed_q         <= armed_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_rx_q      <= shift_rx_d;
            shift_tx_q      <= shift_tx_d;
            holding_q       <= holding_d;
            tx_ready_q      <= tx_ready_d;
            byte_pend_q     <= byte_pend_d;
            word_pend_q     <= word_pend_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            frame_error_q   <= frame_error_d;
        end
    end

    assign frame_active  = (state_q == ST_ACTIVE);
    assign spi_miso_oe   = frame_active;
    assign spi_miso      = frame_active & tx_bit;
    assign tx_ready      = tx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign frame_error   = frame_error_q;
endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench: four 32-bit slaves (one per SPI mode) and one 8-bit LSB-first slave, driven by a bit-banged master.
module tb_spi_slave_frame;
    localparam int H = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  sclk, cs_n, tx_load;
    logic        mosi;
    logic [31:0] tx_data;
    logic [4:0]  miso, oe, tx_ready, rx_valid, rx_byte_valid, frame_active, frame_error;
    logic [31:0] rx_data [4];
    logic [7:0]  rx_data4;
    logic [7:0]  rx_byte [5];

    int          checks = 0;
    int          errors = 0;
    int          byte_cnt [5];
    int          word_cnt [5];
    int          ferr_cnt [5];
    logic [7:0]  byte_log [5][16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_frame #(
            .DATA_BYTES(4), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .MSB_FIRST(1)
        ) dut (
            .clk(clk), .reset(reset), .spi_clk(sclk[g]), .spi_mosi(mosi), .spi_cs_n(cs_n[g]),
            .spi_miso(miso[g]), .spi_miso_oe(oe[g]), .tx_data(tx_data), .tx_load(tx_load[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .rx_byte(rx_byte[g]), .rx_byte_valid(rx_byte_valid[g]),
            .frame_active(frame_active[g]), .frame_error(frame_error[g])
        );
    end

    spi_slave_frame #(
        .DATA_BYTES(1), .CPOL(0), .CPHA(0), .SYNC_STAGES(2), .MSB_FIRST(0)
    ) dut_lsb (
        .clk(clk), .reset(reset), .spi_clk(sclk[4]), .spi_mosi(mosi), .spi_cs_n(cs_n[4]),
        .spi_miso(miso[4]), .spi_miso_oe(oe[4]), .tx_data(tx_data[7:0]), .tx_load(tx_load[4]),
        .tx_ready(tx_ready[4]), .rx_data(rx_data4), .rx_valid(rx_valid[4]),
        .rx_byte(rx_byte[4]), .rx_byte_valid(rx_byte_valid[4]),
        .frame_active(frame_active[4]), .frame_error(frame_error[4])
    );

    initial begin
        for (int m = 0; m < 5; m++) begin
            byte_cnt[m] = 0;
            word_cnt[m] = 0;
            ferr_cnt[m] = 0;
        end
    end

    always @(negedge clk) begin
        for (int m = 0; m < 5; m++) begin
            if (rx_byte_valid[m]) begin
                byte_log[m][byte_cnt[m] % 16] <= rx_byte[m];
                byte_cnt[m] <= byte_cnt[m] + 1;
            end
            if (rx_valid[m])    word_cnt[m] <= word_cnt[m] + 1;
            if (frame_error[m]) ferr_cnt[m] <= ferr_cnt[m] + 1;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int m, input logic [31:0] d);
        @(negedge clk);
        tx_data    = d;
        tx_load[m] = 1'b1;
        @(negedge clk);
        tx_load[m] = 1'b0;
    endtask

    // Bit-banged master; instance 4 is LSB first, the others MSB first.
    task automatic xfer(input int m, input logic [63:0] data, input int nbits, output logic [63:0] got);
        logic cpol, cpha, b, s;
        cpol = (m == 2 || m == 3);
        cpha = (m == 1 || m == 3);
        got  = '0;
        s    = 1'b0;
        cs_n[m] = 1'b0;
        wait_neg(H);
        for (int i = 0; i < nbits; i++) begin
            b = (m == 4) ? data[i] : data[nbits-1-i];
            if (!cpha) begin
                mosi = b;
                wait_neg(H);
                sclk[m] = ~cpol;
                s = miso[m];
                wait_neg(H);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi = b;
                wait_neg(H);
                sclk[m] = cpol;
                s = miso[m];
                wait_neg(H);
            end
            if (m == 4) got[i] = s;
            else        got = {got[62:0], s};
        end
        wait_neg(H);
        cs_n[m] = 1'b1;
        wait_neg(H);
    endtask

    initial begin
        logic [63:0] got;
        int b0, w0, f0;
        reset   = 1'b1;
        sclk    = 5'b01100;
        cs_n    = '1;
        mosi    = 1'b0;
        tx_load = '0;
        tx_data = '0;
        wait_neg(3);
        reset = 1'b0;
        wait_neg(6);

        check("rst_tx_ready", tx_ready, 5'h1f);
        check("rst_active", frame_active, 5'h00);
        check("rst_oe_miso", {oe, miso}, 10'h000);
        check("rst_rx_data", rx_data[0], 32'h0);

        // Mode 0 word exchange
        load(0, 32'hCAFEBABE);
        check("m0_tx_ready_loaded", tx_ready[0], 1'b0);
        b0 = byte_cnt[0]; w0 = word_cnt[0]; f0 = ferr_cnt[0];
        xfer(0, 64'h12345678, 32, got);
        wait_neg(10);
        check("m0_miso", got[31:0], 32'hCAFEBABE);
        check("m0_rx_data", rx_data[0], 32'h12345678);
        check("m0_words", word_cnt[0] - w0, 1);
        check("m0_bytes", byte_cnt[0] - b0, 4);
        check("m0_byte_seq", {byte_log[0][b0 % 16], byte_log[0][(b0+1) % 16],
                              byte_log[0][(b0+2) % 16], byte_log[0][(b0+3) % 16]}, 32'h12345678);
        check("m0_no_ferr", ferr_cnt[0] - f0, 0);
        check("m0_tx_ready_done", tx_ready[0], 1'b1);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            load(m, 32'hCAFEBABE);
            w0 = word_cnt[m];
            xfer(m, 64'h12345678, 32, got);
            wait_neg(10);
            check($sformatf("m%0d_miso", m), got[31:0], 32'hCAFEBABE);
            check($sformatf("m%0d_rx_data", m), rx_data[m], 32'h12345678);
            check($sformatf("m%0d_words", m), word_cnt[m] - w0, 1);
        end

        // Two back-to-back words, new reply loaded mid word 1
        w0 = word_cnt[0];
        fork
            xfer(0, {32'h0BADF00D, 32'hDEADBEEF}, 64, got);
            begin
                wait_neg(200);
                load(0, 32'hA5A5A5A5);
            end
        join
        wait_neg(10);
        check("b2b_miso", got, {32'hCAFEBABE, 32'hA5A5A5A5});
        check("b2b_words", word_cnt[0] - w0, 2);
        check("b2b_rx_data", rx_data[0], 32'hDEADBEEF);
        check("b2b_tx_ready", tx_ready[0], 1'b1);

        // Truncated frame of 12 bits, then a good frame
        b0 = byte_cnt[0]; w0 = word_cnt[0]; f0 = ferr_cnt[0];
        xfer(0, 64'hABC, 12, got);
        wait_neg(10);
        check("trunc_miso", got[11:0], 12'hA5A);
        check("trunc_bytes", byte_cnt[0] - b0, 1);
        check("trunc_byte_val", byte_log[0][b0 % 16], 8'hAB);
        check("trunc_words", word_cnt[0] - w0, 0);
        check("trunc_ferr", ferr_cnt[0] - f0, 1);
        xfer(0, 64'h87654321, 32, got);
        wait_neg(10);
        check("after_trunc_miso", got[31:0], 32'hA5A5A5A5);
        check("after_trunc_rx", rx_data[0], 32'h87654321);
        check("after_trunc_words", word_cnt[0] - w0, 1);
        check("after_trunc_ferr", ferr_cnt[0] - f0, 1);

        // Reset during bit 20 with CS still low
        fork
            xfer(0, 64'h11111111, 32, got);
            begin
                wait_neg(H + 20 * 2 * H + 4);
                reset = 1'b1;
                wait_neg(2);
                check("midrst_active", frame_active, 5'h00);
                check("midrst_tx_ready", tx_ready, 5'h1f);
                check("midrst_outs", {oe, miso, rx_valid, rx_byte_valid, frame_error}, 25'h0);
                check("midrst_rx", {rx_data[0], rx_byte[0]}, 40'h0);
                reset = 1'b0;
                b0 = byte_cnt[0]; w0 = word_cnt[0]; f0 = ferr_cnt[0];
                wait_neg(60);
                check("midrst_stay_idle", {frame_active[0], oe[0], miso[0]}, 3'b000);
            end
        join
        wait_neg(10);
        check("midrst_no_bytes", byte_cnt[0] - b0, 0);
        check("midrst_no_words", word_cnt[0] - w0, 0);
        check("midrst_no_ferr", ferr_cnt[0] - f0, 0);
        load(0, 32'hCAFEBABE);
        w0 = word_cnt[0];
        xfer(0, 64'h5A5A0FF0, 32, got);
        wait_neg(10);
        check("postrst_miso", got[31:0], 32'hCAFEBABE);
        check("postrst_rx", rx_data[0], 32'h5A5A0FF0);
        check("postrst_words", word_cnt[0] - w0, 1);

        // LSB-first single-byte slave
        load(4, 32'h00000080);
        b0 = byte_cnt[4]; w0 = word_cnt[4];
        xfer(4, 64'h01, 8, got);
        wait_neg(10);
        check("lsb_miso", got[7:0], 8'h80);
        check("lsb_rx_byte", byte_log[4][b0 % 16], 8'h01);
        check("lsb_rx_data", rx_data4, 8'h01);
        check("lsb_counts", {byte_cnt[4] - b0, word_cnt[4] - w0}, {32'd1, 32'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
